lift_c: RTL and testbench

Single-car elevator controller for a 64-floor shaft (floors 0–63). It latches floor requests into a pending-request bitmap and moves the car one floor per clock using a SCAN policy (keep direction while requests remain ahead). It opens the door at each requested floor and reports direction, stop and door status. It sits between the floor/cabin request encoder and the motor/door actuator drivers.

---
 rtl/lift_c_pkg.sv | 21 ++
 rtl/lift_c_minmax.sv | 25 ++
 rtl/lift_c.sv | 171 +++++++++++++++++
 tb/tb_lift_c.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lift_c_pkg.sv
// Shared definitions for the lift_c elevator controller.
// Optional build macro: LIFTC_DOOR_DWELL_EN (multi-cycle door dwell).
package lift_c_pkg;

  localparam int NUM_FLOORS   = 64;
  localparam int FLOOR_W      = 7;
  localparam int DWELL_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } lift_state_t;

  // Status outputs are 2-bit wide with only bit 0 ever meaningful.
  function automatic logic [1:0] status_flag(input logic on);
    return {1'b0, on};
  endfunction

endpackage

// File: rtl/lift_c_minmax.sv
// Priority encoder over the pending-request bitmap: highest and lowest
// set index plus a non-empty flag. Indices read 0 when the bitmap is empty.
module lift_c_minmax
  import lift_c_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] vec_i,
  output logic [5:0]            hi_o,
  output logic [5:0]            lo_o,
  output logic                  any_o
);

  // Ascending scan leaves the highest set index, descending scan the lowest.
  always_comb begin
    hi_o  = 6'd0;
    lo_o  = 6'd0;
    any_o = |vec_i;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      hi_o = vec_i[i] ? 6'(i) : hi_o;
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      lo_o = vec_i[i] ? 6'(i) : lo_o;
    end
  end

endmodule

// File: rtl/lift_c.sv
// Single-car SCAN elevator controller: request bitmap, floor counter and FSM.
// Optional build macro: LIFTC_DOOR_DWELL_EN stretches DOOR_OPEN to DWELL_CYCLES.
module lift_c
  import lift_c_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [1:0]            stop,
  output logic [1:0]            door,
  output logic [1:0]            Up,
  output logic [1:0]            Down,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request,
  output logic [NUM_FLOORS-1:0] requests
);

  lift_state_t           state_q, state_d;
  logic [5:0]            floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] requests_q, requests_d;
  logic [NUM_FLOORS-1:0] set_vec_s, clr_vec_s;
  logic [5:0]            max_s, min_s, floor_up_s, floor_dn_s;
  logic                  any_s, above_s, below_s;

`ifdef LIFTC_DOOR_DWELL_EN
  localparam logic [1:0] DwellLast = 2'(DWELL_CYCLES - 1);
  logic [1:0] dwell_q, dwell_d;
`endif

  lift_c_minmax u_minmax (
    .vec_i (requests_q),
    .hi_o  (max_s),
    .lo_o  (min_s),
    .any_o (any_s)
  );

  assign floor_up_s = floor_q + 6'd1;
  assign floor_dn_s = floor_q - 6'd1;
  assign above_s    = any_s && (max_s > floor_q);
  assign below_s    = any_s && (min_s < floor_q);

  // New request decode; out-of-range floors and the car's own floor are dropped.
  always_comb begin
    set_vec_s = {NUM_FLOORS{1'b0}};
    if (!req_floor[6] && (req_floor[5:0] != floor_q)) begin
      set_vec_s[req_floor[5:0]] = 1'b1;
    end else begin
      set_vec_s = {NUM_FLOORS{1'b0}};
    end
  end

  // Next-state, floor movement and arrival clear for the SCAN FSM.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    clr_vec_s = {NUM_FLOORS{1'b0}};
`ifdef LIFTC_DOOR_DWELL_EN
    dwell_d   = dwell_q;
`endif
    case (state_q)
      IDLE: begin
        if (above_s) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (below_s) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end
      MOVE_UP: begin
        // The bound check only matters if the bitmap were corrupted.
        if (floor_q != 6'd63) begin
          floor_d = floor_up_s;
          if (requests_q[floor_up_s]) begin
            clr_vec_s[floor_up_s] = 1'b1;
            state_d               = DOOR_OPEN;
`ifdef LIFTC_DOOR_DWELL_EN
            dwell_d               = DwellLast;
`endif
          end else begin
            state_d = MOVE_UP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (floor_q != 6'd0) begin
          floor_d = floor_dn_s;
          if (requests_q[floor_dn_s]) begin
            clr_vec_s[floor_dn_s] = 1'b1;
            state_d               = DOOR_OPEN;
`ifdef LIFTC_DOOR_DWELL_EN
            dwell_d               = DwellLast;
`endif
          end else begin
            state_d = MOVE_DOWN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DOOR_OPEN: begin
`ifdef LIFTC_DOOR_DWELL_EN
        if (dwell_q != 2'd0) begin
          dwell_d = dwell_q - 2'd1;
          state_d = DOOR_OPEN;
        end else
`endif
        if (dir_up_q && above_s) begin
          state_d = MOVE_UP;
        end else if (below_s) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end else if (above_s) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arrival clear wins over a simultaneous set of the same floor.
  assign requests_d = (requests_q | set_vec_s) & ~clr_vec_s;

  // State, position, direction and bitmap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      floor_q    <= 6'd0;
      dir_up_q   <= 1'b1;
      requests_q <= {NUM_FLOORS{1'b0}};
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      requests_q <= requests_d;
    end
  end

`ifdef LIFTC_DOOR_DWELL_EN
  // Door dwell counter, reloaded on each DOOR_OPEN entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dwell_q <= 2'd0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`endif

  assign stop          = status_flag((state_q == IDLE) || (state_q == DOOR_OPEN));
  assign door          = status_flag(state_q == DOOR_OPEN);
  assign Up            = status_flag(state_q == MOVE_UP);
  assign Down          = status_flag(state_q == MOVE_DOWN);
  assign current_floor = {1'b0, floor_q};
  assign max_request   = {1'b0, max_s};
  assign min_request   = {1'b0, min_s};
  assign requests      = requests_q;

endmodule

// File: tb/tb_lift_c.sv
// Self-checking bench for lift_c: directed scenarios plus random requests,
// every cycle compared against a behavioural SCAN model.
module tb_lift_c;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  req_floor;
  logic [1:0]  stop, door, Up, Down;
  logic [6:0]  current_floor, max_request, min_request;
  logic [63:0] requests;

  int total = 0;
  int bad   = 0;

`ifdef LIFTC_DOOR_DWELL_EN
  localparam int DW = 4;
`else
  localparam int DW = 1;
`endif

  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_DOWN = 2;
  localparam int S_DOOR = 3;

  int          m_state;
  int          m_floor;
  bit          m_dir;
  bit [63:0]   m_req;
  int          m_dwell;

  lift_c dut (
    .clk           (clk),
    .reset         (reset),
    .req_floor     (req_floor),
    .stop          (stop),
    .door          (door),
    .Up            (Up),
    .Down          (Down),
    .current_floor (current_floor),
    .max_request   (max_request),
    .min_request   (min_request),
    .requests      (requests)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int top_req(input bit [63:0] v);
    int r = -1;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int bot_req(input bit [63:0] v);
    int r = 64;
    for (int i = 63; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference behaviour of one rising edge.
  task automatic model_edge(input logic [6:0] r, input logic rst);
    int        hi, lo;
    bit        above, below;
    bit [63:0] nreq;
    if (!rst) begin
      m_state = S_IDLE; m_floor = 0; m_dir = 1'b1; m_req = '0; m_dwell = 0;
      return;
    end
    hi    = top_req(m_req);
    lo    = bot_req(m_req);
    above = (hi >= 0) && (hi > m_floor);
    below = (hi >= 0) && (lo < m_floor);
    nreq  = m_req;
    if (int'(r) < 64 && int'(r) != m_floor) nreq[r] = 1'b1;
    case (m_state)
      S_IDLE: begin
        if (above) begin m_state = S_UP; m_dir = 1'b1; end
        else if (below) begin m_state = S_DOWN; m_dir = 1'b0; end
      end
      S_UP: begin
        if (m_floor < 63) begin
          m_floor++;
          if (m_req[m_floor]) begin nreq[m_floor] = 1'b0; m_state = S_DOOR; m_dwell = DW - 1; end
        end else m_state = S_IDLE;
      end
      S_DOWN: begin
        if (m_floor > 0) begin
          m_floor--;
          if (m_req[m_floor]) begin nreq[m_floor] = 1'b0; m_state = S_DOOR; m_dwell = DW - 1; end
        end else m_state = S_IDLE;
      end
      default: begin
        if (m_dwell > 0) m_dwell--;
        else if (m_dir && above) m_state = S_UP;
        else if (below) begin m_state = S_DOWN; m_dir = 1'b0; end
        else if (above) begin m_state = S_UP; m_dir = 1'b1; end
        else m_state = S_IDLE;
      end
    endcase
    m_req = nreq;
  endtask

  task automatic check_all();
    int hi = top_req(m_req);
    int lo = bot_req(m_req);
    chk("stop",  64'(stop),  64'((m_state == S_IDLE || m_state == S_DOOR) ? 1 : 0));
    chk("door",  64'(door),  64'((m_state == S_DOOR) ? 1 : 0));
    chk("up",    64'(Up),    64'((m_state == S_UP) ? 1 : 0));
    chk("down",  64'(Down),  64'((m_state == S_DOWN) ? 1 : 0));
    chk("floor", 64'(current_floor), 64'(m_floor));
    chk("requests", requests, m_req);
    chk("max_request", 64'(max_request), 64'((hi < 0) ? 0 : hi));
    chk("min_request", 64'(min_request), 64'((hi < 0) ? 0 : lo));
  endtask

  task automatic step(input logic [6:0] r, input logic rst);
    reset     = rst;
    req_floor = r;
    @(posedge clk);
    model_edge(r, rst);
    #1;
    check_all();
  endtask

  // Step with no request until the door closes (if open) and then opens again.
  task automatic wait_door(input string tag);
    int n = 0;
    while (door === 2'b01 && n < 20) begin step(7'd64, 1'b1); n++; end
    n = 0;
    while (door !== 2'b01 && n < 200) begin step(7'd64, 1'b1); n++; end
    chk({tag, "_door_timeout"}, 64'(door), 64'd1);
  endtask

  initial begin
    logic [6:0] r;
    logic       rs;
    m_state = S_IDLE; m_floor = 0; m_dir = 1'b1; m_req = '0; m_dwell = 0;
    reset = 1'b0;
    req_floor = 7'd64;

    step(7'd64, 1'b0);
    step(7'd64, 1'b0);
    chk("rst_floor", 64'(current_floor), 64'd0);
    chk("rst_req",   requests, 64'd0);
    chk("rst_stop",  64'(stop), 64'd1);
    chk("rst_move",  64'({door, Up, Down}), 64'd0);

    // Request 27 held: door opens at request edge + 28.
    step(7'd27, 1'b1);
    for (int i = 0; i < 27; i++) step(7'd27, 1'b1);
    chk("up_27", 64'(Up), 64'd1);
    step(7'd27, 1'b1);
    chk("arrive27_floor", 64'(current_floor), 64'd27);
    chk("arrive27_door",  64'(door), 64'd1);
    chk("arrive27_req",   requests, 64'd0);
    step(7'd27, 1'b1);
    chk("held27_stop", 64'(stop), 64'd1);
    chk("held27_req",  requests, 64'd0);

    step(7'd3, 1'b1);
    step(7'd64, 1'b1);
    step(7'd64, 1'b1);
    chk("down_to3", 64'(Down), 64'd1);
    wait_door("to3");
    chk("at3", 64'(current_floor), 64'd3);

    step(7'd15, 1'b1); step(7'd10, 1'b1); step(7'd6, 1'b1); step(7'd20, 1'b1);
    wait_door("to6");
    chk("at6", 64'(current_floor), 64'd6);
    chk("at6_max", 64'(max_request), 64'd20);
    chk("at6_min", 64'(min_request), 64'd10);
    wait_door("to10");
    chk("at10", 64'(current_floor), 64'd10);
    chk("at10_min", 64'(min_request), 64'd15);
    wait_door("to15");
    chk("at15", 64'(current_floor), 64'd15);
    chk("at15_min", 64'(min_request), 64'd20);
    wait_door("to20");
    chk("at20", 64'(current_floor), 64'd20);
    chk("at20_max", 64'(max_request), 64'd0);

    step(7'd16, 1'b1); step(7'd17, 1'b1);
    wait_door("to17");
    chk("at17", 64'(current_floor), 64'd17);
    wait_door("to16");
    chk("at16", 64'(current_floor), 64'd16);
    chk("at16_req", requests, 64'd0);

    step(7'd64, 1'b1);
    step(7'd127, 1'b1);
    chk("ignored_req", requests, 64'd0);

    // Reset in the middle of an upward run.
    step(7'd50, 1'b1);
    for (int i = 0; i < 8; i++) step(7'd64, 1'b1);
    chk("mid_up", 64'(Up), 64'd1);
    step(7'd40, 1'b0);
    chk("mid_rst_floor", 64'(current_floor), 64'd0);
    chk("mid_rst_req",   requests, 64'd0);
    chk("mid_rst_stop",  64'(stop), 64'd1);
    chk("mid_rst_up",    64'(Up), 64'd0);

    // Sparse random requests with rare resets.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 63)) : 7'($urandom_range(64, 127));
      rs = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(r, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
